// File: rtl/d5m_pattern_tx.sv
// Synthetic D5M sensor source: generates FVAL/LVAL framing and 12-bit Bayer test patterns
// with programmable geometry, standing in for the camera header during bring-up.
`timescale 1ns/1ps
module d5m_pattern_tx #(
    parameter int unsigned H_ACTIVE  = 1280,
    parameter int unsigned V_ACTIVE  = 960,
    parameter int unsigned H_BLANK   = 32,
    parameter int unsigned FV_LEAD   = 4,
    parameter int unsigned FV_TRAIL  = 4,
    parameter int unsigned V_BLANK   = 64,
    parameter int unsigned BAR_SHIFT = 7
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    input  logic [1:0]  iMODE,
    input  logic [11:0] iCONST,
    output logic [11:0] oD,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [15:0] oFRAME_CNT,
    output logic        oBUSY
);

    localparam logic [15:0] HA_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] VA_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] FL_LAST = 16'(FV_LEAD - 1);
    localparam logic [15:0] FT_LAST = 16'(FV_TRAIL - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StLine,
        StHblank,
        StTrail,
        StVblank
    } state_e;

    state_e      state;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] cnt;
    logic [1:0]  mode;
    logic [11:0] const_val;

    function automatic logic [11:0] pixel(input logic [11:0] px, input logic [11:0] py,
                                          input logic [1:0] m, input logic [11:0] c);
        logic [2:0]  bar;
        logic [11:0] r_ch;
        logic [11:0] g_ch;
        logic [11:0] b_ch;
        bar  = 3'(px >> BAR_SHIFT);
        r_ch = bar[2] ? 12'hFFF : 12'h000;
        g_ch = bar[1] ? 12'hFFF : 12'h000;
        b_ch = bar[0] ? 12'hFFF : 12'h000;
        unique case (m)
            2'd0: pixel = px + py;
            2'd1: begin
                // Bayer site from (row parity, column parity): G R / B G
                unique case ({py[0], px[0]})
                    2'b01:   pixel = r_ch;
                    2'b10:   pixel = b_ch;
                    default: pixel = g_ch;
                endcase
            end
            2'd2: pixel = (px[3] ^ py[3]) ? 12'hFFF : 12'h000;
            default: pixel = c;
        endcase
    endfunction

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= StIdle;
            x          <= '0;
            y          <= '0;
            cnt        <= '0;
            mode       <= '0;
            const_val  <= '0;
            oD         <= '0;
            oFVAL      <= 1'b0;
            oLVAL      <= 1'b0;
            oFRAME_CNT <= '0;
            oBUSY      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (iSTART) begin
                        state     <= StLead;
                        mode      <= iMODE;
                        const_val <= iCONST;
                        cnt       <= '0;
                        oFVAL     <= 1'b1;
                        oBUSY     <= 1'b1;
                    end
                end
                StLead: begin
                    if (cnt == FL_LAST) begin
                        state <= StLine;
                        x     <= '0;
                        y     <= '0;
                        oLVAL <= 1'b1;
                        oD    <= pixel(12'd0, 12'd0, mode, const_val);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StLine: begin
                    if (x == HA_LAST) begin
                        oLVAL <= 1'b0;
                        oD    <= '0;
                        cnt   <= '0;
                        state <= (y == VA_LAST) ? StTrail : StHblank;
                    end else begin
                        x  <= x + 16'd1;
                        oD <= pixel(x[11:0] + 12'd1, y[11:0], mode, const_val);
                    end
                end
                StHblank: begin
                    if (cnt == HB_LAST) begin
                        state <= StLine;
                        x     <= '0;
                        y     <= y + 16'd1;
                        oLVAL <= 1'b1;
                        oD    <= pixel(12'd0, y[11:0] + 12'd1, mode, const_val);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StTrail: begin
                    if (cnt == FT_LAST) begin
                        state      <= StVblank;
                        cnt        <= '0;
                        oFVAL      <= 1'b0;
                        oFRAME_CNT <= oFRAME_CNT + 16'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StVblank: begin
                    if (cnt == VB_LAST) begin
                        cnt <= '0;
                        if (iSTART) begin
                            state     <= StLead;
                            mode      <= iMODE;
                            const_val <= iCONST;
                            oFVAL     <= 1'b1;
                        end else begin
                            state <= StIdle;
                            oBUSY <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
